// File: rtl/fighter_palette_sched.sv
// Shares one combinational sprite palette between the two fighter pipelines,
// composites the two sprites over the background and applies per-fighter hit-flash.
module fighter_palette_sched #(
    parameter int unsigned FLASH_FRAMES = 16,
    parameter logic [11:0] FLASH_RGB    = 12'hFFF,
    parameter bit          BG_PASS      = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        pix_en,
    input  logic [3:0]  p1_index,
    input  logic [3:0]  p2_index,
    input  logic [11:0] bg_rgb,
    input  logic        p2_front,
    input  logic        vsync_n,
    input  logic        p1_hit,
    input  logic        p2_hit,
    output logic [3:0]  pal_index,
    input  logic [11:0] pal_rgb,
    output logic [11:0] rgb_out,
    output logic        rgb_valid,
    output logic        busy,
    output logic        overrun,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOOK1 = 2'd1;
    localparam logic [1:0] LOOK2 = 2'd2;
    localparam logic [1:0] EMIT  = 2'd3;

    localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);

    // Handshake: pix_en is a one-cycle strobe accepted only in IDLE (busy=0);
    // rgb_valid is a one-cycle strobe with no back-pressure from the mapper.
    logic [1:0]  state_q, state_d;
    logic [3:0]  hold_p1_q, hold_p2_q;
    logic [11:0] hold_bg_q;
    logic        hold_front_q;
    logic [11:0] c1_q;
    logic        t1_q;
    logic [3:0]  pal_last_q;
    logic [11:0] rgb_out_q;
    logic        rgb_valid_q;
    logic        overrun_q;
    logic [1:0]  vs_q;
    logic [7:0]  flash1_q, flash1_d;
    logic [7:0]  flash2_q, flash2_d;

    logic        tick;
    logic        t2;
    logic [11:0] col1, col2, bg_col, mix;

    assign busy      = (state_q != IDLE);
    assign rgb_out   = rgb_out_q;
    assign rgb_valid = rgb_valid_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;
    assign tick      = vs_q[1] & ~vs_q[0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pix_en) state_d = LOOK1;
            LOOK1:   state_d = LOOK2;
            LOOK2:   state_d = EMIT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pal_index = pal_last_q;
        if (state_q == LOOK1)      pal_index = hold_p1_q;
        else if (state_q == LOOK2) pal_index = hold_p2_q;
    end

    // Fighter 2's colour comes straight off the palette in LOOK2 so the
    // composite can be registered on entry to EMIT.
    always_comb begin
        col1   = flash1_q[0] ? FLASH_RGB : c1_q;
        col2   = flash2_q[0] ? FLASH_RGB : pal_rgb;
        t2     = (hold_p2_q == 4'd0);
        bg_col = BG_PASS ? hold_bg_q : 12'h000;
        if (hold_front_q) mix = !t2 ? col2 : (!t1_q ? col1 : bg_col);
        else              mix = !t1_q ? col1 : (!t2 ? col2 : bg_col);
    end

    always_comb begin
        flash1_d = flash1_q;
        flash2_d = flash2_q;
        if (p1_hit)                         flash1_d = FLASH_LOAD;
        else if (tick && flash1_q != 8'd0)  flash1_d = flash1_q - 8'd1;
        if (p2_hit)                         flash2_d = FLASH_LOAD;
        else if (tick && flash2_q != 8'd0)  flash2_d = flash2_q - 8'd1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            hold_p1_q    <= 4'd0;
            hold_p2_q    <= 4'd0;
            hold_bg_q    <= 12'h000;
            hold_front_q <= 1'b0;
            c1_q         <= 12'h000;
            t1_q         <= 1'b1;
            pal_last_q   <= 4'd0;
            rgb_out_q    <= 12'h000;
            rgb_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            vs_q         <= 2'b11;
            flash1_q     <= 8'd0;
            flash2_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            pal_last_q  <= pal_index;
            vs_q        <= {vs_q[0], vsync_n};
            flash1_q    <= flash1_d;
            flash2_q    <= flash2_d;
            rgb_valid_q <= (state_q == LOOK2);
            if (pix_en && busy) overrun_q <= 1'b1;
            if (state_q == IDLE && pix_en) begin
                hold_p1_q    <= p1_index;
                hold_p2_q    <= p2_index;
                hold_bg_q    <= bg_rgb;
                hold_front_q <= p2_front;
            end
            if (state_q == LOOK1) begin
                c1_q <= pal_rgb;
                t1_q <= (hold_p1_q == 4'd0);
            end
            if (state_q == LOOK2) rgb_out_q <= mix;
        end
    end

endmodule
